// File: rtl/irq_dispatch_master_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_dispatch_master_if
// Brief    : Register-bus bundle between the IRQ dispatcher and the
//            interrupt controller's enable/ack/pending registers.
// Revision : 1.0 - initial release
// ============================================================================
interface irq_dispatch_master_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                  m_read;
   logic                  m_write;
   logic [ADDR_WIDTH-1:0] m_address;
   logic [DATA_WIDTH-1:0] m_write_data;
   logic [DATA_WIDTH-1:0] m_read_data;
   logic                  m_access_complete;

   modport master (
      output m_read,
      output m_write,
      output m_address,
      output m_write_data,
      input  m_read_data,
      input  m_access_complete
   );

   modport slave (
      input  m_read,
      input  m_write,
      input  m_address,
      input  m_write_data,
      output m_read_data,
      output m_access_complete
   );
endinterface
`default_nettype wire

// File: rtl/irq_dispatch_master.sv
`default_nettype none
// ============================================================================
// Module   : irq_dispatch_master
// Brief    : Enables all lines at start-up, then drains the pending register
//            one vector at a time (lowest index first), acking each.
// Revision : 1.0 - initial release
// ============================================================================
module irq_dispatch_master #(
   parameter int                    INTR_WIDTH      = 8,
   parameter int                    ADDR_WIDTH      = 5,
   parameter int                    DATA_WIDTH      = 32,
   parameter bit                    IRQ_ACTIVESTATE = 1'b1,
   parameter logic [INTR_WIDTH-1:0] ENABLE_INIT     = {INTR_WIDTH{1'b1}},
   parameter int                    TIMEOUT         = 15,
   localparam int                   c_ID_WIDTH      = (INTR_WIDTH > 1) ? $clog2(INTR_WIDTH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  irq_in,
   irq_dispatch_master_if.master bus,
   output logic                  vec_valid,
   output logic [c_ID_WIDTH-1:0] vec_id,
   input  logic                  vec_ready,
   output logic                  busy,
   output logic                  bus_error
);

   localparam logic [2:0] c_INIT_WR  = 3'd0;
   localparam logic [2:0] c_IDLE     = 3'd1;
   localparam logic [2:0] c_RD_PEND  = 3'd2;
   localparam logic [2:0] c_DISPATCH = 3'd3;
   localparam logic [2:0] c_WR_ACK   = 3'd4;

   localparam logic [ADDR_WIDTH-1:0] c_ADDR_ENABLE = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] c_ADDR_ACK    = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] c_ADDR_PEND   = ADDR_WIDTH'(8);
   localparam logic [7:0]            c_TIMEOUT     = 8'(TIMEOUT);

   logic [2:0]            r_state;
   logic [7:0]            r_wait;
   logic                  r_req;
   logic                  r_bus_error;
   logic [c_ID_WIDTH-1:0] r_vec_id;

   logic [INTR_WIDTH-1:0] w_pend;
   logic [c_ID_WIDTH-1:0] w_low_id;
   logic                  w_bus_state;
   logic                  w_done;
   logic                  w_timeout;
   logic                  w_req_set;
   logic                  w_req_clr;
   logic                  w_rd;
   logic                  w_wr;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_unused_rd;

   assign w_pend      = bus.m_read_data[INTR_WIDTH-1:0];
   assign w_unused_rd = ^bus.m_read_data;

   // Scan downward so the lowest set bit is the last (winning) assignment.
   always_comb begin
      w_low_id = '0;
      for (int i = INTR_WIDTH - 1; i >= 0; i--) begin
         if (w_pend[i]) begin
            w_low_id = c_ID_WIDTH'(i);
         end
      end
   end

   assign w_bus_state = (r_state == c_INIT_WR) || (r_state == c_RD_PEND) ||
                        (r_state == c_WR_ACK);
   assign w_done      = w_bus_state && bus.m_access_complete;
   // Completion on the last allowed cycle still wins over the timeout.
   assign w_timeout   = w_bus_state && !bus.m_access_complete && (r_wait >= c_TIMEOUT);
   assign w_req_set   = (irq_in == IRQ_ACTIVESTATE);
   assign w_req_clr   = w_timeout || ((r_state == c_RD_PEND) && w_done && (w_pend == '0));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= c_INIT_WR;
         r_wait      <= 8'd0;
         r_req       <= 1'b0;
         r_bus_error <= 1'b0;
         r_vec_id    <= '0;
      end else begin
         r_req       <= w_req_set | (r_req & ~w_req_clr);
         r_bus_error <= w_timeout;
         r_wait      <= 8'd0;
         if (w_bus_state && !w_done && !w_timeout) begin
            r_wait <= r_wait + 8'd1;
         end
         if (w_timeout) begin
            r_state <= c_IDLE;
         end else begin
            case (r_state)
               c_INIT_WR: begin
                  if (w_done) r_state <= c_IDLE;
               end
               c_IDLE: begin
                  if (r_req) r_state <= c_RD_PEND;
               end
               c_RD_PEND: begin
                  if (w_done) begin
                     if (w_pend == '0) begin
                        r_state <= c_IDLE;
                     end else begin
                        r_state  <= c_DISPATCH;
                        r_vec_id <= w_low_id;
                     end
                  end
               end
               c_DISPATCH: begin
                  if (vec_ready) r_state <= c_WR_ACK;
               end
               c_WR_ACK: begin
                  // Re-read pending so remaining lines drain without a new irq.
                  if (w_done) r_state <= c_RD_PEND;
               end
               default: r_state <= c_IDLE;
            endcase
         end
      end
   end

   // Strobes decode straight from state; gating with reset aborts an access at once.
   always_comb begin
      w_rd    = 1'b0;
      w_wr    = 1'b0;
      w_addr  = '0;
      w_wdata = '0;
      if (!reset) begin
         case (r_state)
            c_INIT_WR: begin
               w_wr    = 1'b1;
               w_addr  = c_ADDR_ENABLE;
               w_wdata = DATA_WIDTH'(ENABLE_INIT);
            end
            c_RD_PEND: begin
               w_rd   = 1'b1;
               w_addr = c_ADDR_PEND;
            end
            c_WR_ACK: begin
               w_wr    = 1'b1;
               w_addr  = c_ADDR_ACK;
               w_wdata = DATA_WIDTH'(1) << r_vec_id;
            end
            default: begin
               w_rd = 1'b0;
            end
         endcase
      end
   end

   assign bus.m_read       = w_rd;
   assign bus.m_write      = w_wr;
   assign bus.m_address    = w_addr;
   assign bus.m_write_data = w_wdata;

   assign vec_valid = !reset && (r_state == c_DISPATCH);
   assign vec_id    = vec_valid ? r_vec_id : '0;
   assign busy      = !reset && (r_state != c_IDLE);
   assign bus_error = !reset && r_bus_error;

endmodule
`default_nettype wire

// File: tb/tb_irq_dispatch_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_dispatch_master
// Brief    : Directed bench for irq_dispatch_master with a bus responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_dispatch_master;

   logic       clk = 1'b0;
   logic       reset;
   logic       irq_in;
   logic       vec_valid;
   logic [2:0] vec_id;
   logic       vec_ready;
   logic       busy;
   logic       bus_error;
   int         checks = 0;
   int         errors = 0;

   irq_dispatch_master_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

   irq_dispatch_master #(
      .INTR_WIDTH      (8),
      .ADDR_WIDTH      (5),
      .DATA_WIDTH      (32),
      .IRQ_ACTIVESTATE (1'b1),
      .ENABLE_INIT     (8'hFF),
      .TIMEOUT         (15)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .irq_in    (irq_in),
      .bus       (bus),
      .vec_valid (vec_valid),
      .vec_id    (vec_id),
      .vec_ready (vec_ready),
      .busy      (busy),
      .bus_error (bus_error)
   );

   always #5 clk = ~clk;

   // Strobes are exclusive, and address/data are zero while no strobe is up.
   always @(negedge clk) begin
      checks++;
      if ((bus.m_read && bus.m_write) ||
          (!bus.m_read && !bus.m_write && (bus.m_address !== 5'h0 || bus.m_write_data !== 32'h0))) begin
         errors++;
         $display("FAIL bus_quiet: rd=%0b wr=%0b addr=%h data=%h, want exclusive strobes and 0 when idle",
                  bus.m_read, bus.m_write, bus.m_address, bus.m_write_data);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic pulse_irq();
      irq_in = 1'b1;
      @(negedge clk);
      irq_in = 1'b0;
   endtask

   task automatic bus_access(input int delay, input logic [31:0] rdata, input logic irq_at_done,
                             output logic seen, output logic is_wr,
                             output logic [4:0] addr, output logic [31:0] wdata);
      seen = 1'b0; is_wr = 1'b0; addr = '0; wdata = '0;
      for (int i = 0; i < 40; i++) begin
         if (bus.m_read || bus.m_write) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (seen) begin
         is_wr = bus.m_write;
         addr  = bus.m_address;
         wdata = bus.m_write_data;
         repeat (delay) @(negedge clk);
         bus.m_access_complete = 1'b1;
         bus.m_read_data       = rdata;
         if (irq_at_done) irq_in = 1'b1;
         @(negedge clk);
         bus.m_access_complete = 1'b0;
         bus.m_read_data       = '0;
         irq_in                = 1'b0;
      end
   endtask

   task automatic take_vec(input int stall, output logic seen, output logic [2:0] id,
                           output logic stable);
      seen = 1'b0; id = '0; stable = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (vec_valid) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (seen) begin
         id = vec_id;
         for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (!vec_valid || vec_id !== id || bus.m_read || bus.m_write) stable = 1'b0;
         end
         vec_ready = 1'b1;
         @(negedge clk);
         vec_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic s, w;
      logic [4:0] a;
      logic [31:0] d;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.m_read, bus.m_write} !== 2'b00) begin
         errors++; $display("FAIL reset_strobes: got %b want 00", {bus.m_read, bus.m_write});
      end
      checks++;
      if ({busy, vec_valid, bus_error} !== 3'b000) begin
         errors++; $display("FAIL reset_status: busy/valid/err got %b want 000", {busy, vec_valid, bus_error});
      end
      checks++;
      if (vec_id !== 3'd0) begin
         errors++; $display("FAIL reset_vec_id: got %0d want 0", vec_id);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (!(bus.m_write && !bus.m_read && bus.m_address === 5'h00 && bus.m_write_data === 32'hFF)) begin
         errors++; $display("FAIL first_cycle_write: wr=%0b addr=%h data=%h want 1/00/000000ff",
                            bus.m_write, bus.m_address, bus.m_write_data);
      end
      bus_access(2, 32'h0, 1'b0, s, w, a, d);
      checks++;
      if (!(s && w && a === 5'h00 && d === 32'h000000FF)) begin
         errors++; $display("FAIL init_write: seen=%0b wr=%0b addr=%h data=%h want 1/1/00/000000ff", s, w, a, d);
      end
      checks++;
      if (busy !== 1'b0 || bus.m_write !== 1'b0) begin
         errors++; $display("FAIL init_to_idle: busy=%0b wr=%0b want 0/0", busy, bus.m_write);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL idle_stays: busy=%0b want 0", busy);
      end
   endtask

   task automatic test_drain();
      logic s, w, st;
      logic [4:0] a;
      logic [31:0] d;
      logic [2:0] id;
      pulse_irq();
      bus_access(1, 32'h24, 1'b0, s, w, a, d);
      checks++;
      if (!(s && !w && a === 5'h08)) begin
         errors++; $display("FAIL drain_rd1: seen=%0b wr=%0b addr=%h want read at 08", s, w, a);
      end
      take_vec(0, s, id, st);
      checks++;
      if (!s || id !== 3'd2) begin
         errors++; $display("FAIL drain_vec1: seen=%0b id=%0d want 2", s, id);
      end
      bus_access(0, 32'h0, 1'b0, s, w, a, d);
      checks++;
      if (!(s && w && a === 5'h04 && d === 32'h04)) begin
         errors++; $display("FAIL drain_ack1: wr=%0b addr=%h data=%h want 1/04/00000004", w, a, d);
      end
      bus_access(0, 32'h20, 1'b0, s, w, a, d);
      checks++;
      if (!(s && !w && a === 5'h08)) begin
         errors++; $display("FAIL drain_rd2: seen=%0b wr=%0b addr=%h want read at 08", s, w, a);
      end
      take_vec(0, s, id, st);
      checks++;
      if (!s || id !== 3'd5) begin
         errors++; $display("FAIL drain_vec2: seen=%0b id=%0d want 5", s, id);
      end
      bus_access(0, 32'h0, 1'b0, s, w, a, d);
      checks++;
      if (!(s && w && a === 5'h04 && d === 32'h20)) begin
         errors++; $display("FAIL drain_ack2: wr=%0b addr=%h data=%h want 1/04/00000020", w, a, d);
      end
      bus_access(0, 32'h0, 1'b0, s, w, a, d);
      checks++;
      if (!(s && !w && a === 5'h08)) begin
         errors++; $display("FAIL drain_rd3: seen=%0b wr=%0b addr=%h want read at 08", s, w, a);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || bus.m_read !== 1'b0) begin
         errors++; $display("FAIL drain_idle: busy=%0b rd=%0b want 0/0", busy, bus.m_read);
      end
   endtask

   task automatic test_dispatch_stall();
      logic s, w, st;
      logic [4:0] a;
      logic [31:0] d;
      logic [2:0] id;
      pulse_irq();
      bus_access(0, 32'h24, 1'b0, s, w, a, d);
      take_vec(10, s, id, st);
      checks++;
      if (!s || id !== 3'd2) begin
         errors++; $display("FAIL stall_vec: seen=%0b id=%0d want 2", s, id);
      end
      checks++;
      if (st !== 1'b1) begin
         errors++; $display("FAIL stall_stable: stable=%0b want 1 (valid, id, no strobe)", st);
      end
      bus_access(0, 32'h0, 1'b0, s, w, a, d);
      checks++;
      if (!(s && w && a === 5'h04 && d === 32'h04)) begin
         errors++; $display("FAIL stall_ack: wr=%0b addr=%h data=%h want 1/04/00000004", w, a, d);
      end
      bus_access(0, 32'h0, 1'b0, s, w, a, d);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL stall_idle: busy=%0b want 0", busy);
      end
   endtask

   task automatic test_timeout();
      int cnt;
      cnt = 0;
      pulse_irq();
      for (int i = 0; i < 10 && !bus.m_read; i++) @(negedge clk);
      while (bus.m_read && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      checks++;
      if (cnt !== 16) begin
         errors++; $display("FAIL timeout_len: strobe cycles got %0d want 16", cnt);
      end
      checks++;
      if ({bus_error, busy, bus.m_read} !== 3'b100) begin
         errors++; $display("FAIL timeout_pulse: err/busy/rd got %b want 100", {bus_error, busy, bus.m_read});
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bus_error, busy} !== 2'b00) begin
         errors++; $display("FAIL timeout_after: err/busy got %b want 00", {bus_error, busy});
      end
   endtask

   task automatic test_timeout_boundary();
      logic s, w;
      logic [4:0] a;
      logic [31:0] d;
      pulse_irq();
      bus_access(15, 32'h0, 1'b0, s, w, a, d);
      checks++;
      if (!(s && !w && a === 5'h08)) begin
         errors++; $display("FAIL boundary_rd: seen=%0b wr=%0b addr=%h want read at 08", s, w, a);
      end
      checks++;
      if ({bus_error, busy} !== 2'b00) begin
         errors++; $display("FAIL boundary_ok: err/busy got %b want 00", {bus_error, busy});
      end
   endtask

   task automatic test_irq_vs_clear();
      logic s, w;
      logic [4:0] a;
      logic [31:0] d;
      pulse_irq();
      bus_access(0, 32'h0, 1'b1, s, w, a, d);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL race_idle: busy=%0b want 0 (one IDLE cycle)", busy);
      end
      @(negedge clk);
      checks++;
      if (!(bus.m_read && bus.m_address === 5'h08)) begin
         errors++; $display("FAIL race_reread: rd=%0b addr=%h want 1/08", bus.m_read, bus.m_address);
      end
      bus_access(0, 32'h0, 1'b0, s, w, a, d);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || bus.m_read !== 1'b0) begin
         errors++; $display("FAIL race_settle: busy=%0b rd=%0b want 0/0", busy, bus.m_read);
      end
   endtask

   task automatic test_reset_in_ack();
      logic s, w, st;
      logic [4:0] a;
      logic [31:0] d;
      logic [2:0] id;
      pulse_irq();
      bus_access(0, 32'h01, 1'b0, s, w, a, d);
      take_vec(0, s, id, st);
      checks++;
      if (!(id === 3'd0 && bus.m_write && bus.m_address === 5'h04 && bus.m_write_data === 32'h1)) begin
         errors++; $display("FAIL rstack_inack: id=%0d wr=%0b addr=%h data=%h want 0/1/04/00000001",
                            id, bus.m_write, bus.m_address, bus.m_write_data);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.m_write, busy} !== 2'b00) begin
         errors++; $display("FAIL rstack_abort: wr/busy got %b want 00", {bus.m_write, busy});
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      bus_access(1, 32'h0, 1'b0, s, w, a, d);
      checks++;
      if (!(s && w && a === 5'h00 && d === 32'hFF)) begin
         errors++; $display("FAIL rstack_init: seen=%0b wr=%0b addr=%h data=%h want 1/1/00/000000ff", s, w, a, d);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL rstack_idle: busy=%0b want 0", busy);
      end
   endtask

   initial begin
      reset                 = 1'b1;
      irq_in                = 1'b0;
      vec_ready             = 1'b0;
      bus.m_read_data       = '0;
      bus.m_access_complete = 1'b0;
      test_reset();
      test_drain();
      test_dispatch_stall();
      test_timeout();
      test_timeout_boundary();
      test_irq_vs_clear();
      test_reset_in_ack();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/irq_dispatch_master.md
IRQ_DISPATCH_MASTER -- requirements
Module: irq_dispatch_master

Interface
REQ-001 SHALL have parameter INTR_WIDTH, default 8, number of interrupt lines serviced.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, bus address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, bus data width; must be at least INTR_WIDTH.
REQ-004 SHALL have parameter IRQ_ACTIVESTATE, default 1, irq_in active level (1 = high, 0 = low).
REQ-005 SHALL have parameter ENABLE_INIT, default all-ones (INTR_WIDTH bits), enable mask written after reset.
REQ-006 SHALL have parameter TIMEOUT, default 15, maximum wait cycles per bus access; valid range 1..255.
REQ-007 clk  input  1  clock; all logic on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 irq_in  input  1  interrupt request from the interrupt controller (level or single-cycle pulse).
REQ-010 m_read  output  1  bus read strobe, held until completion.
REQ-011 m_write  output  1  bus write strobe, held until completion.
REQ-012 m_address  output  ADDR_WIDTH  byte address: 0x00 enable, 0x04 ack, 0x08 pending.
REQ-013 m_write_data  output  DATA_WIDTH  write data, zero-extended.
REQ-014 m_read_data  input  DATA_WIDTH  read data, valid while m_access_complete=1.
REQ-015 m_access_complete  input  1  completes the current access.
REQ-016 vec_valid  output  1  dispatch vector valid.
REQ-017 vec_id  output  $clog2(INTR_WIDTH)  index of the interrupt being dispatched.
REQ-018 vec_ready  input  1  handler accepts the vector.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 bus_error  output  1  one-cycle pulse on access timeout.

Function
REQ-021 SHALL implement the states INIT_WR, IDLE, RD_PEND, DISPATCH and WR_ACK.
REQ-022 INIT_WR: m_write=1, address 0x00, data ENABLE_INIT; on completion -> IDLE.
REQ-023 A sticky req flag SHALL set on any cycle with irq_in==IRQ_ACTIVESTATE; single-cycle pulses are captured.
REQ-024 IDLE with req=1 -> RD_PEND on the next cycle.
REQ-025 RD_PEND: m_read=1, address 0x08; on completion, capture m_read_data[INTR_WIDTH-1:0] in the same cycle.
REQ-026 After capture: captured value zero -> IDLE and clear req; nonzero -> DISPATCH with vec_id = lowest set bit index.
REQ-027 If the clear of req and an active irq_in coincide, the set SHALL win.
REQ-028 DISPATCH: vec_valid=1 and vec_id stable until the cycle with vec_ready=1; then -> WR_ACK.
REQ-029 DISPATCH SHALL have no timeout.
REQ-030 WR_ACK: m_write=1, address 0x04, data one-hot at bit vec_id.
REQ-031 WR_ACK on completion -> RD_PEND; pending is re-read until it is zero, so draining needs no new irq.
REQ-032 m_read and m_write SHALL never both be high, and SHALL deassert in the cycle after completion is sampled.
REQ-033 Wait counter (8 bit) SHALL clear on entering each bus state and increment each cycle without completion.
REQ-034 When the wait counter reaches TIMEOUT: drop the strobe, pulse bus_error, clear req, go to IDLE (from INIT_WR also to IDLE).
REQ-035 Completion in the same cycle the counter reaches TIMEOUT SHALL count as success, not error.
REQ-036 m_address and m_write_data SHALL be 0 whenever no strobe is active.

Reset
REQ-037 Reset SHALL force state INIT_WR, req=0 and wait counter 0.
REQ-038 During reset all outputs SHALL be 0.
REQ-039 The first post-reset cycle SHALL drive m_write=1 at address 0x00.
REQ-040 Reset asserted mid-access SHALL abort that access with no completion handshake.

Verification
REQ-041 Reset release, complete after 2 cycles -> write 0x00 = 0x000000FF, then IDLE with busy=0.
REQ-042 irq_in one-cycle pulse, pending read 0x00000024 -> vec_id=2 dispatched and acked with 0x04; re-read returns 0x20 -> vec_id=5 acked with 0x20; re-read returns 0 -> IDLE.
REQ-043 vec_ready held low for 10 cycles in DISPATCH -> vec_valid and vec_id=2 stable and no bus strobe for those 10 cycles.
REQ-044 m_access_complete never asserted during RD_PEND -> bus_error pulses after 15 wait cycles, strobe drops, state IDLE.
REQ-045 irq_in active in the same cycle as a zero pending read -> req stays set and RD_PEND re-entered after one IDLE cycle.
REQ-046 Reset asserted during WR_ACK -> m_write low next cycle, then the INIT_WR sequence repeats.
